// File: rtl/weight_load_ctrl_if.sv
// Handshake bundle between the top-level control FSM / weight source and
// the weight-load sequencer.
// The stall_cycles member exists only when WEIGHT_LOAD_CTRL_PERF_EN is defined.
interface weight_load_ctrl_if #(
    parameter int ROWS  = 8,
    parameter int ROW_W = $clog2(ROWS)
) ();
    logic             trigger_weight;
    logic [ROW_W:0]   num_rows;
    logic             weight_valid;
    logic             abort;
    logic             weight_ready;
    logic             load;
    logic [ROW_W-1:0] row_idx;
    logic             busy;
    logic             systolic_done;
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
    logic [15:0]      stall_cycles;
`endif

    // Control / weight-source side
    modport master (
        output trigger_weight,
        output num_rows,
        output weight_valid,
        output abort,
        input  weight_ready,
        input  load,
        input  row_idx,
        input  busy,
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
        input  stall_cycles,
`endif
        input  systolic_done
    );

    // Sequencer side
    modport slave (
        input  trigger_weight,
        input  num_rows,
        input  weight_valid,
        input  abort,
        output weight_ready,
        output load,
        output row_idx,
        output busy,
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
        output stall_cycles,
`endif
        output systolic_done
    );
endinterface

// File: rtl/weight_load_ctrl.sv
// Parametrised weight-load sequencer for the systolic array.
// On an accepted trigger it walks row_idx across n_eff rows, gating each row
// write with the weight_valid/weight_ready handshake, waits SETTLE_CYCLES
// idle cycles and then pulses systolic_done for one cycle.
// Optional feature macro: WEIGHT_LOAD_CTRL_PERF_EN adds a 16-bit saturating
// stall_cycles counter of LOAD cycles without weight_valid.
module weight_load_ctrl #(
    parameter int ROWS          = 8,
    parameter int ROW_W         = $clog2(ROWS),
    parameter int SETTLE_CYCLES = 1
) (
    input logic clk,
    input logic rst,
    weight_load_ctrl_if.slave wl
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ROW_W:0]   ROWS_L      = (ROW_W + 1)'(ROWS);
    localparam logic [SET_W-1:0] SETTLE_LAST =
        SET_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] row_cnt;
    logic [ROW_W:0]   n_eff_q;
    logic [SET_W-1:0] settle_cnt;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    // A zero or oversized request means "load every physical row".
    function automatic logic [ROW_W:0] calc_n_eff(input logic [ROW_W:0] req);
        if (req == '0 || req > ROWS_L)
            return ROWS_L;
        return req;
    endfunction

    // Saturating increment for the 16-bit performance counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Sequencer FSM; outputs other than load are registered alongside state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row_cnt    <= '0;
            n_eff_q    <= '0;
            settle_cnt <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Trigger wins over a simultaneous abort here.
                    if (wl.trigger_weight) begin
                        n_eff_q <= calc_n_eff(wl.num_rows);
                        row_cnt <= '0;
                        state   <= LOAD;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (wl.abort) begin
                        state   <= IDLE;
                        row_cnt <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (wl.weight_valid) begin
                        if ({1'b0, row_cnt} == n_eff_q - 1'b1) begin
                            row_cnt <= '0;
                            ready_q <= 1'b0;
                            if (SETTLE_CYCLES > 0) begin
                                state <= SETTLE;
                            end else begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (wl.abort) begin
                        state      <= IDLE;
                        settle_cnt <= '0;
                        busy_q     <= 1'b0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= DONE;
                        done_q     <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Abort is ignored here so the done pulse always completes.
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WEIGHT_LOAD_CTRL_PERF_EN
    logic [15:0] stall_q;

    // Counts LOAD cycles without weight_valid; held after the job ends.
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (state == IDLE && wl.trigger_weight)
            stall_q <= '0;
        else if (state == LOAD && !wl.weight_valid)
            stall_q <= sat_inc16(stall_q);
    end

    assign wl.stall_cycles = stall_q;
`endif

    // load is the only output with a deliberate combinational path from
    // inputs: the write strobe must follow weight_valid in the same cycle,
    // and a row presented together with abort is never written.
    assign wl.load          = ready_q & wl.weight_valid & ~wl.abort;
    assign wl.weight_ready  = ready_q;
    assign wl.row_idx       = row_cnt;
    assign wl.busy          = busy_q;
    assign wl.systolic_done = done_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: stimulus pushes expected load/done
// events (row and absolute cycle) into per-instance queues; a negedge monitor
// pops and compares whenever a DUT raises load or systolic_done.
// Instance u_dut1 uses SETTLE_CYCLES=1, instance u_dut0 uses SETTLE_CYCLES=0.
module tb_weight_load_ctrl;

    typedef struct {
        bit is_done;
        int row;
        int cyc;
    } evt_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    evt_t q1[$];
    evt_t q0[$];

    weight_load_ctrl_if #(.ROWS(8)) bus1 ();
    weight_load_ctrl_if #(.ROWS(8)) bus0 ();

    weight_load_ctrl #(.ROWS(8), .SETTLE_CYCLES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .wl  (bus1)
    );

    weight_load_ctrl #(.ROWS(8), .SETTLE_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .wl  (bus0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic push_evt(input int which, input bit dn, input int row, input int c);
        evt_t e;
        e.is_done = dn;
        e.row     = row;
        e.cyc     = c;
        if (which == 1) q1.push_back(e);
        else            q0.push_back(e);
    endtask

    task automatic chk_evt(input int which, input bit dn, input int row);
        evt_t e;
        n_cmp++;
        if ((which == 1 && q1.size() == 0) || (which == 0 && q0.size() == 0)) begin
            n_err++;
            $display("FAIL unexpected_%s dut%0d at cycle %0d: got row %0d, expected no event",
                     dn ? "done" : "load", which, cyc, row);
        end else begin
            if (which == 1) e = q1.pop_front();
            else            e = q0.pop_front();
            if (e.is_done != dn || e.row != row || e.cyc != cyc) begin
                n_err++;
                $display("FAIL event dut%0d: got %s row %0d cycle %0d, expected %s row %0d cycle %0d",
                         which, dn ? "done" : "load", row, cyc,
                         e.is_done ? "done" : "load", e.row, e.cyc);
            end
        end
    endtask

    // Monitor: compare every presented load / done against the scoreboard
    always @(negedge clk) begin
        if (bus1.load === 1'b1)          chk_evt(1, 1'b0, int'(bus1.row_idx));
        if (bus1.systolic_done === 1'b1) chk_evt(1, 1'b1, 0);
        if (bus0.load === 1'b1)          chk_evt(0, 1'b0, int'(bus0.row_idx));
        if (bus0.systolic_done === 1'b1) chk_evt(0, 1'b1, 0);
    end

    initial begin
        #100000;
        $display("FAIL timeout at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        rst = 1'b1;
        bus1.trigger_weight = 1'b0; bus1.num_rows = '0; bus1.weight_valid = 1'b1; bus1.abort = 1'b0;
        bus0.trigger_weight = 1'b0; bus0.num_rows = '0; bus0.weight_valid = 1'b0; bus0.abort = 1'b0;
        repeat (3) step();

        // Reset state (weight_valid high must not leak onto load)
        chk("rst_busy",  int'(bus1.busy), 0);
        chk("rst_ready", int'(bus1.weight_ready), 0);
        chk("rst_load",  int'(bus1.load), 0);
        chk("rst_row",   int'(bus1.row_idx), 0);
        chk("rst_done",  int'(bus1.systolic_done), 0);
        rst = 1'b0;
        step();

        // Full 8-row job via num_rows=0
        t = cyc;
        bus1.num_rows = 4'd0; bus1.trigger_weight = 1'b1;
        for (int i = 0; i < 8; i++) push_evt(1, 1'b0, i, t + 1 + i);
        push_evt(1, 1'b1, 0, t + 10);
        step();
        bus1.trigger_weight = 1'b0;
        chk("t1_ready", int'(bus1.weight_ready), 1);
        for (int k = 1; k <= 10; k++) begin
            chk("t1_busy", int'(bus1.busy), 1);
            step();
        end
        chk("t1_idle_busy", int'(bus1.busy), 0);
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
        chk("t1_stall", int'(bus1.stall_cycles), 0);
`endif

        // num_rows=3 with one stall cycle
        t = cyc;
        bus1.num_rows = 4'd3; bus1.trigger_weight = 1'b1;
        push_evt(1, 1'b0, 0, t + 1);
        push_evt(1, 1'b0, 1, t + 3);
        push_evt(1, 1'b0, 2, t + 4);
        push_evt(1, 1'b1, 0, t + 6);
        step();
        bus1.trigger_weight = 1'b0;
        step();
        bus1.weight_valid = 1'b0;
        #1;
        chk("t2_stall_row",  int'(bus1.row_idx), 1);
        chk("t2_stall_load", int'(bus1.load), 0);
        step();
        bus1.weight_valid = 1'b1;
        repeat (4) step();
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
        chk("t2_stall", int'(bus1.stall_cycles), 1);
`endif

        // num_rows=12 saturates to 8 rows
        t = cyc;
        bus1.num_rows = 4'd12; bus1.trigger_weight = 1'b1;
        for (int i = 0; i < 8; i++) push_evt(1, 1'b0, i, t + 1 + i);
        push_evt(1, 1'b1, 0, t + 10);
        step();
        bus1.trigger_weight = 1'b0;
        repeat (10) step();

        // num_rows=1: single row
        t = cyc;
        bus1.num_rows = 4'd1; bus1.trigger_weight = 1'b1;
        push_evt(1, 1'b0, 0, t + 1);
        push_evt(1, 1'b1, 0, t + 3);
        step();
        bus1.trigger_weight = 1'b0;
        repeat (3) step();

        // Abort during row 4 of an 8-row job, then restart
        t = cyc;
        bus1.num_rows = 4'd8; bus1.trigger_weight = 1'b1;
        for (int i = 0; i < 4; i++) push_evt(1, 1'b0, i, t + 1 + i);
        step();
        bus1.trigger_weight = 1'b0;
        repeat (4) step();
        bus1.abort = 1'b1;
        #1;
        chk("t4_abort_load", int'(bus1.load), 0);
        chk("t4_abort_row",  int'(bus1.row_idx), 4);
        step();
        bus1.abort = 1'b0;
        chk("t4_idle_busy", int'(bus1.busy), 0);
        chk("t4_idle_row",  int'(bus1.row_idx), 0);
        t = cyc;
        bus1.num_rows = 4'd2; bus1.trigger_weight = 1'b1;
        push_evt(1, 1'b0, 0, t + 1);
        push_evt(1, 1'b0, 1, t + 2);
        push_evt(1, 1'b1, 0, t + 4);
        step();
        bus1.trigger_weight = 1'b0;
        repeat (4) step();

        // Triggers during LOAD and SETTLE are ignored
        t = cyc;
        bus1.num_rows = 4'd3; bus1.trigger_weight = 1'b1;
        for (int i = 0; i < 3; i++) push_evt(1, 1'b0, i, t + 1 + i);
        push_evt(1, 1'b1, 0, t + 5);
        step();
        bus1.trigger_weight = 1'b0;
        step();
        bus1.trigger_weight = 1'b1;
        step();
        bus1.trigger_weight = 1'b0;
        step();
        bus1.trigger_weight = 1'b1;
        step();
        bus1.trigger_weight = 1'b0;
        step();
        chk("t5_idle_busy", int'(bus1.busy), 0);

        // Trigger and abort together in IDLE: trigger wins
        t = cyc;
        bus1.num_rows = 4'd1; bus1.trigger_weight = 1'b1; bus1.abort = 1'b1;
        push_evt(1, 1'b0, 0, t + 1);
        push_evt(1, 1'b1, 0, t + 3);
        step();
        bus1.trigger_weight = 1'b0; bus1.abort = 1'b0;
        repeat (3) step();

        // Reset mid-LOAD: no done, outputs back to idle
        t = cyc;
        bus1.num_rows = 4'd0; bus1.trigger_weight = 1'b1;
        for (int i = 0; i < 5; i++) push_evt(1, 1'b0, i, t + 1 + i);
        step();
        bus1.trigger_weight = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t7_busy",  int'(bus1.busy), 0);
        chk("t7_row",   int'(bus1.row_idx), 0);
        chk("t7_load",  int'(bus1.load), 0);
        chk("t7_ready", int'(bus1.weight_ready), 0);
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
        chk("t7_stall", int'(bus1.stall_cycles), 0);
`endif
        repeat (12) step();

        // SETTLE_CYCLES=0 instance, num_rows=2
        t = cyc;
        bus0.num_rows = 4'd2; bus0.weight_valid = 1'b1; bus0.trigger_weight = 1'b1;
        push_evt(0, 1'b0, 0, t + 1);
        push_evt(0, 1'b0, 1, t + 2);
        push_evt(0, 1'b1, 0, t + 3);
        step();
        bus0.trigger_weight = 1'b0;
        repeat (3) step();
        chk("t8_idle_busy", int'(bus0.busy), 0);

        repeat (3) step();
        chk("pending_dut1", q1.size(), 0);
        chk("pending_dut0", q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
